// File: rtl/acc_ctrl_pkg.sv
// Shared definitions for the accumulator issue controller: opcode values,
// instruction field positions and the controller state encoding.
package acc_ctrl_pkg;

    // Opcodes 0x0-0x7 are ALU operations forwarded untouched to the ALU.
    localparam logic [3:0] OP_ADD     = 4'h0;
    localparam logic [3:0] OP_SUB     = 4'h1;
    localparam logic [3:0] OP_ALU_MAX = 4'h7;
    localparam logic [3:0] OP_LDA     = 4'h8;
    localparam logic [3:0] OP_STA     = 4'h9;
    localparam logic [3:0] OP_NOP     = 4'hE;
    localparam logic [3:0] OP_HLT     = 4'hF;

    // Instruction word layout: [31:28] opcode, [27] imm flag, [26:0] field.
    localparam int INSTR_W   = 32;
    localparam int OPC_MSB   = 31;
    localparam int OPC_LSB   = 28;
    localparam int IMM_BIT   = 27;
    localparam int FIELD_MSB = 26;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DECODE = 3'd1,
        MEM    = 3'd2,
        EXEC   = 3'd3,
        WB     = 3'd4,
        HALT   = 3'd5
    } state_t;

endpackage

// File: rtl/acc_instr_decode.sv
// Combinational decode of the latched instruction word into the class
// flags the controller FSM branches on, plus the zero-extended immediate.
module acc_instr_decode #(
    parameter int DATA_W = 32
) (
    input  logic [31:0]       instr,
    output logic              is_alu,
    output logic              is_lda,
    output logic              is_sta,
    output logic              is_halt,
    output logic              needs_mem,
    output logic [DATA_W-1:0] operand_imm
);
    import acc_ctrl_pkg::*;

    logic [3:0] op;
    logic       imm;

    assign op  = instr[OPC_MSB:OPC_LSB];
    assign imm = instr[IMM_BIT];

    // Classify the opcode; reserved codes and NOP fall through as "nothing".
    always_comb begin
        is_alu      = (op <= OP_ALU_MAX);
        is_lda      = (op == OP_LDA);
        is_sta      = (op == OP_STA);
        is_halt     = (op == OP_HLT);
        // STA always touches memory; loads and ALU ops only without imm.
        needs_mem   = is_sta || ((is_alu || is_lda) && !imm);
        operand_imm = DATA_W'(instr[FIELD_MSB:0]);
    end

endmodule

// File: rtl/acc_exec_ctrl.sv
// Issue controller for the accumulator datapath: accepts instructions,
// fetches memory operands, sequences the clocked ALU and writes results
// back into the architectural accumulator.
// Optional build macro ACC_CTRL_FLAGS_EN adds registered zero/neg flags.
//
// Instruction handshake: a word transfers on a rising execlk edge where
// instr_valid and instr_ready are both 1. instr_ready is high only in IDLE
// (and never while rst is asserted); instr_valid in any other state is
// ignored and the word is not latched.
module acc_exec_ctrl #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
) (
    input  logic              execlk,
    input  logic              rst,
    input  logic              instr_valid,
    input  logic [31:0]       instr,
    output logic              instr_ready,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic [3:0]        alu_opcode,
    output logic [DATA_W-1:0] alu_acc,
    output logic [DATA_W-1:0] alu_data,
    input  logic [DATA_W-1:0] alu_result,
    output logic [DATA_W-1:0] acc_out,
    output logic              busy,
    output logic              halted
`ifdef ACC_CTRL_FLAGS_EN
    ,
    output logic              zero_flag,
    output logic              neg_flag
`endif
);
    import acc_ctrl_pkg::*;

    state_t              state, state_n;
    logic [31:0]         instr_q;
    logic [DATA_W-1:0]   operand_q;
    logic [DATA_W-1:0]   acc_q;
    logic                acc_we;
    logic [DATA_W-1:0]   acc_d;

    logic                is_alu, is_lda, is_sta, is_halt, needs_mem;
    logic [DATA_W-1:0]   operand_imm;

    acc_instr_decode #(.DATA_W(DATA_W)) u_decode (
        .instr       (instr_q),
        .is_alu      (is_alu),
        .is_lda      (is_lda),
        .is_sta      (is_sta),
        .is_halt     (is_halt),
        .needs_mem   (needs_mem),
        .operand_imm (operand_imm)
    );

    // State register; reset discards any in-flight instruction.
    always_ff @(posedge execlk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    // Next-state logic and accumulator write selection.
    always_comb begin
        state_n = state;
        acc_we  = 1'b0;
        acc_d   = alu_result;
        case (state)
            IDLE: begin
                if (instr_valid && instr_ready) state_n = DECODE;
            end
            DECODE: begin
                if (is_halt)        state_n = HALT;
                else if (needs_mem) state_n = MEM;
                else if (is_alu)    state_n = EXEC;
                else begin
                    // Immediate LDA commits here; NOP/reserved do nothing.
                    state_n = IDLE;
                    if (is_lda) begin
                        acc_we = 1'b1;
                        acc_d  = operand_imm;
                    end
                end
            end
            MEM: begin
                if (mem_ack) begin
                    state_n = is_alu ? EXEC : IDLE;
                    if (is_lda) begin
                        acc_we = 1'b1;
                        acc_d  = mem_rdata;
                    end
                end
            end
            EXEC:    state_n = WB;
            WB: begin
                // ALU registered its inputs at the end of EXEC.
                state_n = IDLE;
                acc_we  = 1'b1;
                acc_d   = alu_result;
            end
            HALT:    state_n = HALT;
            default: state_n = IDLE;
        endcase
    end

    // Instruction, operand and accumulator registers.
    always_ff @(posedge execlk or posedge rst) begin
        if (rst) begin
            instr_q   <= '0;
            operand_q <= '0;
            acc_q     <= '0;
        end else begin
            if (state == IDLE && instr_valid && instr_ready) instr_q <= instr;
            if (state == DECODE)             operand_q <= operand_imm;
            else if (state == MEM && mem_ack) operand_q <= mem_rdata;
            if (acc_we) acc_q <= acc_d;
        end
    end

    // Output decode; everything idles at zero outside its active states.
    always_comb begin
        instr_ready = (state == IDLE) && !rst;
        busy        = (state != IDLE) && (state != HALT);
        halted      = (state == HALT);
        mem_req     = (state == MEM);
        mem_we      = mem_req && is_sta;
        mem_addr    = mem_req ? instr_q[ADDR_W-1:0] : '0;
        mem_wdata   = mem_we ? acc_q : '0;
        alu_opcode  = '0;
        alu_acc     = '0;
        alu_data    = '0;
        if (state == EXEC || state == WB) begin
            alu_opcode = instr_q[OPC_MSB:OPC_LSB];
            alu_acc    = acc_q;
            alu_data   = operand_q;
        end
        acc_out     = acc_q;
    end

`ifdef ACC_CTRL_FLAGS_EN
    // Status flags track every accumulator write.
    always_ff @(posedge execlk or posedge rst) begin
        if (rst) begin
            zero_flag <= 1'b1;
            neg_flag  <= 1'b0;
        end else if (acc_we) begin
            zero_flag <= (acc_d == '0);
            neg_flag  <= acc_d[DATA_W-1];
        end
    end
`endif

endmodule

// File: tb/tb_acc_exec_ctrl.sv
// Self-checking bench for acc_exec_ctrl: directed scenarios plus random
// instruction streams, checked cycle by cycle against a behavioural model.
module tb_acc_exec_ctrl;

  logic        execlk = 1'b0;
  logic        rst = 1'b1;
  logic        instr_valid = 1'b0;
  logic [31:0] instr = '0;
  logic        instr_ready;
  logic        mem_req, mem_we;
  logic [15:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;
  logic [3:0]  alu_opcode;
  logic [31:0] alu_acc, alu_data;
  logic [31:0] alu_result = '0;
  logic [31:0] acc_out;
  logic        busy, halted;
`ifdef ACC_CTRL_FLAGS_EN
  logic        zero_flag, neg_flag;
`endif

  acc_exec_ctrl #(.ADDR_W(16), .DATA_W(32)) dut (
    .execlk      (execlk),
    .rst         (rst),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_ready (instr_ready),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .mem_ack     (mem_ack),
    .alu_opcode  (alu_opcode),
    .alu_acc     (alu_acc),
    .alu_data    (alu_data),
    .alu_result  (alu_result),
    .acc_out     (acc_out),
    .busy        (busy),
    .halted      (halted)
`ifdef ACC_CTRL_FLAGS_EN
    ,
    .zero_flag   (zero_flag),
    .neg_flag    (neg_flag)
`endif
  );

  // ---------------- clock / reset ----------------
  always #5 execlk = ~execlk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- environment: ALU and memory ----------------
  function automatic logic [31:0] alu_f(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      4'h0:    return a + b;
      4'h1:    return a - b;
      4'h2:    return a & b;
      4'h3:    return a | b;
      4'h4:    return a ^ b;
      4'h5:    return b;
      4'h6:    return a << b[4:0];
      default: return a >> b[4:0];
    endcase
  endfunction

  // Clocked ALU: result appears one edge after its inputs.
  always @(posedge execlk) alu_result <= alu_f(alu_opcode, alu_acc, alu_data);

  logic [31:0] mem_m [0:63];

  // ---------------- model + scoreboard ----------------
  typedef struct packed {
    logic        ready;
    logic        busy;
    logic        halted;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  alu_opcode;
    logic [31:0] alu_acc;
    logic [31:0] alu_data;
    logic [31:0] acc_out;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] model_acc = '0;
  bit          model_halted = 1'b0;
  int          checks = 0;
  int          failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Single compare process: one expected vector per cycle.
  initial begin
    exp_t e;
    forever begin
      @(posedge execlk);
      #1;
      e = '0;
      if (rst) begin
        e = '0;
      end else if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
      end else begin
        e.ready   = !model_halted;
        e.halted  = model_halted;
        e.acc_out = model_acc;
      end
      chk("instr_ready", {31'b0, instr_ready}, {31'b0, e.ready});
      chk("busy",        {31'b0, busy},        {31'b0, e.busy});
      chk("halted",      {31'b0, halted},      {31'b0, e.halted});
      chk("mem_req",     {31'b0, mem_req},     {31'b0, e.mem_req});
      chk("mem_we",      {31'b0, mem_we},      {31'b0, e.mem_we});
      chk("mem_addr",    {16'b0, mem_addr},    {16'b0, e.mem_addr});
      chk("mem_wdata",   mem_wdata,            e.mem_wdata);
      chk("alu_opcode",  {28'b0, alu_opcode},  {28'b0, e.alu_opcode});
      chk("alu_acc",     alu_acc,              e.alu_acc);
      chk("alu_data",    alu_data,             e.alu_data);
      chk("acc_out",     acc_out,              e.acc_out);
`ifdef ACC_CTRL_FLAGS_EN
      chk("zero_flag",   {31'b0, zero_flag},   {31'b0, (e.acc_out == 32'd0)});
      chk("neg_flag",    {31'b0, neg_flag},    {31'b0, e.acc_out[31]});
`endif
    end
  end

  // ---------------- driver tasks ----------------
  // Called at a negedge; leaves the DUT idle at a negedge.
  task automatic do_reset();
    rst = 1'b1;
    exp_q.delete();
    model_acc = '0;
    model_halted = 1'b0;
    instr_valid = 1'b1;
    mem_ack = 1'b1;
    #1;
    chk("rst_mem_req", {31'b0, mem_req}, 32'd0);
    chk("rst_acc_out", acc_out, 32'd0);
    chk("rst_ready", {31'b0, instr_ready}, 32'd0);
    repeat (2) @(negedge execlk);
    rst = 1'b0;
    instr_valid = 1'b0;
    mem_ack = 1'b0;
  endtask

  // Issue one instruction; w = mem_ack wait cycles; abort_k >= 0 resets
  // the DUT in that cycle of the instruction instead of finishing it.
  task automatic run_instr(input logic [31:0] word, input int w, input int abort_k);
    exp_t        e;
    logic [3:0]  op;
    logic        imm;
    logic [15:0] addr;
    logic [31:0] a, opnd, a_new;
    bit          is_alu, is_lda, is_sta, is_hlt, is_mem;
    int          n;
    op     = word[31:28];
    imm    = word[27];
    addr   = word[15:0];
    a      = model_acc;
    is_alu = (op < 4'h8);
    is_lda = (op == 4'h8);
    is_sta = (op == 4'h9);
    is_hlt = (op == 4'hF);
    is_mem = is_sta || ((is_alu || is_lda) && !imm);
    opnd   = imm ? {5'b0, word[26:0]} : mem_m[addr[5:0]];
    a_new  = is_alu ? alu_f(op, a, opnd) : (is_lda ? opnd : a);

    // Decode cycle.
    e = '0;
    e.busy = 1'b1;
    e.acc_out = a;
    exp_q.push_back(e);
    n = 1;
    if (is_mem) begin
      for (int i = 0; i <= w; i++) begin
        e = '0;
        e.busy = 1'b1;
        e.mem_req = 1'b1;
        e.mem_we = is_sta;
        e.mem_addr = addr;
        e.mem_wdata = is_sta ? a : 32'd0;
        e.acc_out = a;
        exp_q.push_back(e);
        n++;
      end
    end
    if (is_alu) begin
      for (int i = 0; i < 2; i++) begin
        e = '0;
        e.busy = 1'b1;
        e.alu_opcode = op;
        e.alu_acc = a;
        e.alu_data = opnd;
        e.acc_out = a;
        exp_q.push_back(e);
        n++;
      end
    end
    model_acc = a_new;
    if (is_hlt) model_halted = 1'b1;

    instr = word;
    instr_valid = 1'b1;
    for (int k = 0; k < n; k++) begin
      @(posedge execlk);
      @(negedge execlk);
      if (k == abort_k) begin
        do_reset();
        return;
      end
      // Competing words while busy must never be taken.
      instr_valid = ($urandom_range(0, 3) != 0);
      instr = $urandom;
      if (is_mem && k >= 1 && k <= 1 + w) begin
        mem_ack = (k == 1 + w);
        mem_rdata = $urandom;
        if (k == 1 + w) begin
          if (is_sta) mem_m[addr[5:0]] = mem_wdata;
          else        mem_rdata = mem_m[addr[5:0]];
        end
      end else begin
        mem_ack = $urandom_range(0, 1);
        mem_rdata = $urandom;
      end
    end
    @(posedge execlk);
    @(negedge execlk);
    instr_valid = 1'b0;
    mem_ack = $urandom_range(0, 1);
    mem_rdata = $urandom;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [3:0]  op;
    logic        imm;
    logic [31:0] word;
    for (int i = 0; i < 64; i++) mem_m[i] = $urandom;

    // Reset state.
    @(negedge execlk);
    chk("reset_ready", {31'b0, instr_ready}, 32'd0);
    chk("reset_acc", acc_out, 32'd0);
    chk("reset_busy", {31'b0, busy}, 32'd0);
    @(negedge execlk);
    rst = 1'b0;
    #1;
    chk("ready_after_reset", {31'b0, instr_ready}, 32'd1);

    // ADD #5, then SUB [0x10] with mem=3 and two wait cycles.
    run_instr(32'h0800_0005, 0, -1);
    chk("lit_add5", acc_out, 32'd5);
    mem_m[16] = 32'd3;
    run_instr(32'h1000_0010, 2, -1);
    chk("lit_sub_mem", acc_out, 32'd2);

    // LDA/STA round trip.
    run_instr(32'h8800_1234, 0, -1);
    chk("lit_lda_imm", acc_out, 32'h0000_1234);
    run_instr(32'h9000_0020, 1, -1);
    chk("lit_sta_mem", mem_m[32], 32'h0000_1234);
    run_instr(32'h8800_0000, 0, -1);
    run_instr(32'h8000_0020, 3, -1);
    chk("lit_lda_mem", acc_out, 32'h0000_1234);

    // Zero / negative results.
    run_instr(32'h8800_0000, 0, -1);
    run_instr(32'h0800_0000, 0, -1);
    chk("lit_zero_acc", acc_out, 32'd0);
`ifdef ACC_CTRL_FLAGS_EN
    chk("lit_zero_flag", {31'b0, zero_flag}, 32'd1);
`endif
    run_instr(32'h1800_0001, 0, -1);
    chk("lit_neg_acc", acc_out, 32'hFFFF_FFFF);
`ifdef ACC_CTRL_FLAGS_EN
    chk("lit_neg_flag", {31'b0, neg_flag}, 32'd1);
    chk("lit_nz_flag", {31'b0, zero_flag}, 32'd0);
`endif

    // Random instruction stream (no HLT).
    for (int i = 0; i < 150; i++) begin
      op  = 4'($urandom_range(0, 14));
      imm = 1'($urandom_range(0, 1));
      if (imm && op != 4'h9)
        word = {op, imm, 27'($urandom)};
      else
        word = {op, imm, 11'($urandom), 10'b0, 6'($urandom_range(0, 63))};
      run_instr(word, $urandom_range(0, 3), -1);
    end

    // Reset while a memory read is waiting for its ack.
    run_instr(32'h1000_0011, 4, 2);
    chk("lit_acc_after_abort", acc_out, 32'd0);
    run_instr(32'h0800_0007, 0, -1);
    chk("lit_add_after_abort", acc_out, 32'd7);

    // HLT holds off all further instructions until reset.
    run_instr(32'hF000_0000, 0, -1);
    chk("lit_halted", {31'b0, halted}, 32'd1);
    repeat (20) begin
      instr_valid = 1'b1;
      instr = $urandom_range(0, 1) ? 32'h0800_0001 : $urandom;
      @(negedge execlk);
    end
    chk("lit_still_halted", {31'b0, halted}, 32'd1);
    do_reset();
    chk("lit_unhalted", {31'b0, halted}, 32'd0);
    run_instr(32'h0800_0003, 0, -1);
    chk("lit_add_after_halt", acc_out, 32'd3);

    repeat (3) @(negedge execlk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/acc_exec_ctrl.md
Name: acc_exec_ctrl

Overview:
- Issue side of the accumulator datapath. Accepts 32-bit instructions over a valid/ready handshake and decodes them.
- Fetches the memory operand when the instruction needs one, drives opcode/acc/data into the clocked ALU, and writes acc1 back into the architectural accumulator.
- Sits between instruction fetch, data memory and the ALU.

Parameters:
- ADDR_W, 16, data-memory address width; taken from instr[ADDR_W-1:0].
- DATA_W, 32, accumulator/operand width; must match the ALU.

Ports:
- execlk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- instr_valid  in  1  instruction word present.
- instr  in  32  [31:28] opcode, [27] imm flag, [26:0] immediate/address.
- instr_ready  out  1  controller can accept an instruction.
- mem_req  out  1  data-memory request.
- mem_we  out  1  1 = write (STA), 0 = read.
- mem_addr  out  ADDR_W  data-memory address.
- mem_wdata  out  DATA_W  store data (accumulator).
- mem_rdata  in  DATA_W  read data; valid when mem_ack=1.
- mem_ack  in  1  request complete.
- alu_opcode  out  4  to ALU opcode.
- alu_acc  out  DATA_W  to ALU acc.
- alu_data  out  DATA_W  to ALU data.
- alu_result  in  DATA_W  from ALU acc1; registered by the ALU one execlk edge after inputs.
- acc_out  out  DATA_W  architectural accumulator.
- busy  out  1  high in any state other than IDLE and HALT.
- halted  out  1  HLT executed.

Behaviour:
- Reset (async, rst=1): every output is 0, including instr_ready and acc_out. State = IDLE.
- On rst deassertion, instr_ready rises in the first cycle.
- Opcodes:
  - 0x0-0x7: ALU ops, forwarded unchanged (0x0 ADD, 0x1 SUB, ...).
  - 0x8: LDA (acc <= operand).
  - 0x9: STA (mem[addr] <= acc).
  - 0xE: NOP.
  - 0xF: HLT.
  - 0xA-0xD: reserved, executed as NOP.
- Operand: imm=1 → zero-extended instr[26:0]; imm=0 → mem[instr[ADDR_W-1:0]].
- STA always uses the address field and ignores imm.
- FSM:
  - IDLE: instr_ready=1. On instr_valid&&instr_ready, latch the instruction → DECODE. instr_ready is 0 in every other state.
  - DECODE:
    - HLT → HALT.
    - NOP/reserved → IDLE.
    - STA, or imm=0 LDA/ALU op → MEM.
    - imm=1 LDA → acc loaded at this edge → IDLE.
    - imm=1 ALU op → EXEC.
  - MEM: mem_req=1. mem_addr and mem_we are stable while mem_req=1; mem_wdata=acc for STA.
    - On the edge where mem_ack=1: capture mem_rdata and drop mem_req next cycle.
    - Then: ALU op → EXEC; LDA → acc<=rdata → IDLE; STA → IDLE.
  - EXEC: drive alu_opcode/alu_acc=acc/alu_data=operand for exactly one cycle → WB.
  - WB: acc <= alu_result → IDLE. alu_* hold their EXEC values during WB; otherwise alu_* = 0.
  - HALT: halted=1, busy=0, instr_ready=0. Only rst exits.
- Latency, accept edge = T:
  - Immediate ALU op: acc_out updated at edge T+3; instr_ready high in the cycle after T+3.
  - Immediate LDA: acc_out updated at T+1.
  - Memory ops: add one cycle per mem_ack wait cycle; minimum is 1 MEM cycle.
- mem_ack while mem_req=0: ignored.
- instr_valid outside IDLE: ignored, not latched.
- Width rules: arithmetic wrap-around is the ALU's responsibility; the controller never modifies alu_result.
- Reset mid-operation (any state, including MEM with ack pending): outputs clear asynchronously, mem_req drops the same instant, the in-flight instruction is discarded and acc_out=0.

Optional Feature:
- Macro ACC_CTRL_FLAGS_EN.
- Defined: adds outputs zero_flag (acc_out==0) and neg_flag (acc_out[DATA_W-1]).
  - Both are registered and updated on every acc write.
  - Reset to zero_flag=1, neg_flag=0.
- Undefined: the ports do not exist and no flag logic is present.

Decomposition:
- Package acc_ctrl_pkg:
  - opcode localparams: OP_ADD, OP_SUB, OP_LDA, OP_STA, OP_NOP, OP_HLT;
  - state enum/encoding: IDLE, DECODE, MEM, EXEC, WB, HALT;
  - instruction field bit positions.
- Sub-module acc_instr_decode (combinational): latched instr → is_alu, is_lda, is_sta, is_halt, needs_mem, operand_imm. The FSM stays in acc_exec_ctrl.

Test Plan:
- Reset then imm ADD: after rst, 0x0800_0005 (ADD #5) accepted at T → alu_opcode=0, alu_data=5 during EXEC; acc_out=5 at T+3; instr_ready high after.
- Memory SUB: acc=5; 0x1000_0010 (SUB [0x10]), mem returns 3 with mem_ack after 2 wait cycles → mem_req high 3 cycles, mem_we=0, mem_addr=0x10; acc_out=2.
- STA/LDA round trip: LDA #0x1234 → acc=0x1234 at T+1. Then STA [0x20] → mem_we=1, mem_wdata=0x1234, mem_addr=0x20 until ack.
- Backpressure: instr_valid held high with a new word during EXEC → not accepted until IDLE; each instruction executes exactly once.
- HLT: 0xF000_0000 → halted=1, busy=0, instr_ready=0 with instr_valid high for 20 cycles; rst clears halted.
- Reset mid-MEM: assert rst while mem_req=1 and before ack → mem_req=0 immediately, acc_out=0; next instruction executes normally.
- Flags (ACC_CTRL_FLAGS_EN defined): ADD #0 from acc=0 → zero_flag=1; SUB #1 → acc=0xFFFF_FFFF, neg_flag=1, zero_flag=0.
